// File: rtl/pcm_spi_tx_pkg.sv
// Shared definitions for the PCM-to-SPI u-law transmitter.
//   BIAS / CLIP : G.711 u-law encoder constants
//   SILENCE     : u-law code sent when no sample is available
//   state_e     : transmitter FSM state (IDLE, FRAME)
package pcm_spi_tx_pkg;

  localparam int unsigned BIAS    = 132;
  localparam int unsigned CLIP    = 32635;
  localparam logic [7:0]  SILENCE = 8'hFF;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_e;

endpackage

// File: rtl/lin_ulaw_conv.sv
// Combinational G.711 u-law encoder: 16-bit signed linear PCM to 8-bit u-law.
// Inverse counterpart of the u-law to linear converter.
//   lpcm : signed two's-complement linear sample
//   upcm : u-law code (bit-inverted sign/exponent/mantissa)
module lin_ulaw_conv
  import pcm_spi_tx_pkg::*;
(
  input  logic [15:0] lpcm,
  output logic [7:0]  upcm
);

  logic        sign;
  logic [16:0] mag_full;
  logic [14:0] mag;
  logic [14:0] biased;
  logic [2:0]  exponent;
  logic [3:0]  mantissa;

  always_comb begin
    sign     = lpcm[15];
    // 17 bits so that -32768 has a representable magnitude before clipping.
    mag_full = sign ? (17'h10000 - {1'b0, lpcm}) : {1'b0, lpcm};
    mag      = (mag_full > 17'(CLIP)) ? 15'(CLIP) : mag_full[14:0];
    biased   = mag + 15'(BIAS);
    // NOTE: exponent is given a default before the loop so every path assigns it and no latch is inferred.
    exponent = '0;
    // Bias guarantees bit 7 is the lowest possible leading one; last hit wins.
    for (int i = 0; i < 8; i++) begin
      if (biased[i+7]) exponent = 3'(i);
    end
    mantissa = 4'(biased >> (4'(exponent) + 4'd3));
    upcm     = ~{sign, exponent, mantissa};
  end

endmodule

// File: rtl/pcm_spi_tx.sv
// Serial u-law transmitter: accepts linear PCM samples into a one-deep
// holding register (encoded on entry) and shifts each code out MSB first in
// FRAME_BITS-slot frames with a slot-0 frame sync.
//   clk, reset          : block clock, asynchronous active-low reset
//   enable              : serial transmit enable (low aborts the frame)
//   lpcm_in/lpcm_valid  : sample input, accepted when lpcm_ready is high
//   lpcm_ready          : holding register empty
//   spi_clk/fs/data     : generated bit clock, frame sync, serial data
//   underrun            : one-cycle pulse when a frame starts with no sample
module pcm_spi_tx
  import pcm_spi_tx_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int FRAME_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] lpcm_in,
  input  logic        lpcm_valid,
  output logic        lpcm_ready,
  output logic        spi_clk,
  output logic        spi_fs,
  output logic        spi_data,
  output logic        underrun
);

  localparam int DIV_W  = $clog2(2 * CLK_DIV);
  localparam int SLOT_W = $clog2(FRAME_BITS);

  state_e            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_d;
  logic [7:0]        hold_q;
  logic              hold_full_q;
  logic [7:0]        shift_q;
  logic              spi_clk_q;
  logic              spi_fs_q;
  logic              spi_data_q;
  logic              underrun_q;

  logic [7:0] enc_code;
  logic       accept;
  logic       div_wrap;
  logic       frame_start;
  logic [7:0] load_code;

  lin_ulaw_conv u_conv (
    .lpcm (lpcm_in),
    .upcm (enc_code)
  );

  assign accept      = lpcm_valid & ~hold_full_q;
  assign div_wrap    = (div_q == DIV_W'(2 * CLK_DIV - 1));
  assign slot_d      = (slot_q == SLOT_W'(FRAME_BITS - 1)) ? '0 : slot_q + 1'b1;
  // A frame starts either on entry to FRAME or when the last slot wraps.
  assign frame_start = enable & ((state_q == IDLE) | (div_wrap & (slot_d == '0)));
  assign load_code   = hold_full_q ? hold_q : SILENCE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      div_q       <= '0;
      slot_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= SILENCE;
      spi_clk_q   <= 1'b0;
      spi_fs_q    <= 1'b0;
      spi_data_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values; later writes in this block override earlier defaults.
      underrun_q <= 1'b0;
      if (accept) begin
        hold_q      <= enc_code;
        hold_full_q <= 1'b1;
      end
      if (!enable) begin
        state_q    <= IDLE;
        div_q      <= '0;
        slot_q     <= '0;
        spi_clk_q  <= 1'b0;
        spi_fs_q   <= 1'b0;
        spi_data_q <= 1'b0;
      end else if (frame_start) begin
        state_q    <= FRAME;
        div_q      <= '0;
        slot_q     <= '0;
        spi_clk_q  <= 1'b0;
        spi_fs_q   <= 1'b1;
        spi_data_q <= load_code[7];
        shift_q    <= load_code;
        // accept cannot fire here: it needs the holding register empty.
        if (hold_full_q) hold_full_q <= 1'b0;
        else             underrun_q  <= 1'b1;
      end else if (div_wrap) begin
        div_q      <= '0;
        slot_q     <= slot_d;
        spi_clk_q  <= 1'b0;
        spi_fs_q   <= 1'b0;
        // Slot n (1..7) carries code bit 7-n, i.e. the inverted low slot bits.
        spi_data_q <= (slot_d < SLOT_W'(8)) & shift_q[~slot_d[2:0]];
      end else begin
        div_q     <= div_q + 1'b1;
        spi_clk_q <= ((div_q + 1'b1) >= DIV_W'(CLK_DIV));
      end
    end
  end

  assign lpcm_ready = ~hold_full_q;
  assign spi_clk    = spi_clk_q;
  assign spi_fs     = spi_fs_q;
  assign spi_data   = spi_data_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_pcm_spi_tx.sv
// Self-checking bench for pcm_spi_tx (CLK_DIV=2, FRAME_BITS=16).
module tb_pcm_spi_tx;

  localparam int CLK_DIV    = 2;
  localparam int FRAME_BITS = 16;
  localparam int SLOT_CYC   = 2 * CLK_DIV;
  localparam int FRAME_CYC  = SLOT_CYC * FRAME_BITS;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        enable     = 1'b0;
  logic [15:0] lpcm_in    = '0;
  logic        lpcm_valid = 1'b0;
  logic        lpcm_ready;
  logic        spi_clk;
  logic        spi_fs;
  logic        spi_data;
  logic        underrun;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] feed_q[$];
  bit          rdy_seen = 1'b0;

  always #5 clk = ~clk;

  pcm_spi_tx #(.CLK_DIV(CLK_DIV), .FRAME_BITS(FRAME_BITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .lpcm_in    (lpcm_in),
    .lpcm_valid (lpcm_valid),
    .lpcm_ready (lpcm_ready),
    .spi_clk    (spi_clk),
    .spi_fs     (spi_fs),
    .spi_data   (spi_data),
    .underrun   (underrun)
  );

  // Reference u-law encoder computed arithmetically from the G.711 rules.
  function automatic logic [7:0] ref_ulaw(input logic [15:0] x);
    int v, mag, e, m;
    v   = int'($signed(x));
    mag = (v < 0) ? -v : v;
    if (mag > 32635) mag = 32635;
    mag = mag + 132;
    e   = 0;
    while ((mag >> (e + 8)) != 0) e++;
    m   = (mag >> (e + 3)) & 15;
    return ~8'(((v < 0) ? 128 : 0) + e * 16 + m);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and run the sample feeder: a sample is
  // taken by the DUT on the rising edge where valid and ready were both high.
  task automatic tick();
    @(negedge clk);
    if (lpcm_valid && rdy_seen && feed_q.size() > 0) void'(feed_q.pop_front());
    if (feed_q.size() > 0) begin
      lpcm_valid = 1'b1;
      lpcm_in    = feed_q[0];
    end else begin
      lpcm_valid = 1'b0;
      lpcm_in    = '0;
    end
    rdy_seen = lpcm_ready;
  endtask

  task automatic wait_fs(input string tag);
    tick();
    check({tag, "_start"}, 32'(spi_fs), 32'd1);
    for (int k = 0; k < 8 && spi_fs !== 1'b1; k++) tick();
  endtask

  // Called with the first slot-0 cycle visible. rdy_mode: 0 none,
  // 1 ready only in cycle 0 (next sample waiting), 2 ready throughout.
  task automatic check_frame(input string tag, input logic [7:0] code, input bit exp_und,
                             input int ncyc, input int rdy_mode);
    int slot, ph;
    for (int i = 0; i < ncyc; i++) begin
      if (i > 0) tick();
      slot = i / SLOT_CYC;
      ph   = i % SLOT_CYC;
      check({tag, "_clk"}, 32'(spi_clk), 32'(ph >= CLK_DIV));
      check({tag, "_fs"},  32'(spi_fs),  32'(slot == 0));
      check({tag, "_data"}, 32'(spi_data), (slot < 8) ? 32'(code[7 - slot]) : 32'd0);
      check({tag, "_und"}, 32'(underrun), 32'(exp_und && i == 0));
      if (rdy_mode == 1) check({tag, "_rdy"}, 32'(lpcm_ready), 32'(i == 0));
      if (rdy_mode == 2) check({tag, "_rdy"}, 32'(lpcm_ready), 32'd1);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_clk"}, 32'(spi_clk),  32'd0);
    check({tag, "_fs"},  32'(spi_fs),   32'd0);
    check({tag, "_data"}, 32'(spi_data), 32'd0);
    check({tag, "_und"}, 32'(underrun), 32'd0);
  endtask

  logic [15:0] enc_in  [6] = '{16'h0000, 16'h0001, 16'hFFFF, 16'd1000, 16'h7FFF, 16'h8000};
  logic [7:0]  enc_out [6] = '{8'hFF,    8'hFF,    8'h7F,    8'hCE,    8'h80,    8'h00};

  initial begin
    logic [15:0] rnd [4];
    // Asynchronous reset applied before any clock edge.
    #2 reset = 1'b0;
    #1;
    check_idle("rst_init");
    check("rst_init_rdy", 32'(lpcm_ready), 32'd1);
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    check_idle("post_rst");
    check("post_rst_rdy", 32'(lpcm_ready), 32'd1);

    // Encoding of the directed values, observed on the serial line.
    for (int t = 0; t < 6; t++) begin
      feed_q.push_back(enc_in[t]);
      tick(); tick();
      check("enc_held_rdy", 32'(lpcm_ready), 32'd0);
      enable = 1'b1;
      wait_fs("enc");
      check_frame($sformatf("enc%0d", t), enc_out[t], 1'b0, FRAME_CYC, 2);
      enable = 1'b0;
      tick();
      check_idle("enc_stop");
    end

    // Underrun: no sample held, repeated idle cycles never pulse underrun.
    repeat (5) begin
      tick();
      check("idle_und", 32'(underrun), 32'd0);
    end
    enable = 1'b1;
    wait_fs("und");
    check_frame("und", 8'hFF, 1'b1, FRAME_CYC, 2);
    enable = 1'b0;
    tick();
    check_idle("und_stop");

    // Back-to-back streaming with valid held high.
    feed_q.push_back(16'd1000);
    feed_q.push_back(16'hFFFF);
    feed_q.push_back(16'h0000);
    tick(); tick();
    enable = 1'b1;
    wait_fs("strm");
    check_frame("strm0", 8'hCE, 1'b0, FRAME_CYC, 1);
    tick();
    check_frame("strm1", 8'h7F, 1'b0, FRAME_CYC, 1);
    tick();
    check_frame("strm2", 8'hFF, 1'b0, FRAME_CYC, 2);
    enable = 1'b0;
    tick();
    check_idle("strm_stop");

    // Abort at slot 3 with a second sample held; it must survive.
    feed_q.push_back(16'd1000);
    feed_q.push_back(16'h8000);
    tick(); tick();
    enable = 1'b1;
    wait_fs("abrt");
    check_frame("abrt0", 8'hCE, 1'b0, 3 * SLOT_CYC + 1, 1);
    enable = 1'b0;
    tick();
    check_idle("abrt_stop");
    check("abrt_rdy", 32'(lpcm_ready), 32'd0);
    repeat (4) begin
      tick();
      check_idle("abrt_idle");
      check("abrt_idle_rdy", 32'(lpcm_ready), 32'd0);
    end
    enable = 1'b1;
    wait_fs("abrt1");
    check_frame("abrt1", 8'h00, 1'b0, FRAME_CYC, 2);
    enable = 1'b0;
    tick();

    // Reset mid-frame (slot 4, spi_clk high) with a sample held.
    feed_q.push_back(16'd1000);
    feed_q.push_back(16'h7FFF);
    tick(); tick();
    enable = 1'b1;
    wait_fs("mrst");
    check_frame("mrst", 8'hCE, 1'b0, 5 * SLOT_CYC, 1);
    check("mrst_pre_clk", 32'(spi_clk), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_idle("mrst_async");
    check("mrst_rdy", 32'(lpcm_ready), 32'd1);
    enable     = 1'b0;
    lpcm_valid = 1'b0;
    feed_q.delete();
    tick(); tick();
    reset = 1'b1;
    tick();
    check("mrst_rel_rdy", 32'(lpcm_ready), 32'd1);
    enable = 1'b1;
    wait_fs("mrst_post");
    check_frame("mrst_post", 8'hFF, 1'b1, FRAME_CYC, 2);
    enable = 1'b0;
    tick();

    // Randomized streaming against the reference encoder.
    for (int k = 0; k < 4; k++) begin
      rnd[k] = 16'($urandom);
      feed_q.push_back(rnd[k]);
    end
    tick(); tick();
    enable = 1'b1;
    wait_fs("rnd");
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      check_frame($sformatf("rnd%0d_%04h", k, rnd[k]), ref_ulaw(rnd[k]), 1'b0, FRAME_CYC,
                  (k < 3) ? 1 : 2);
    end
    enable = 1'b0;
    tick();
    check_idle("rnd_stop");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
